// File: rtl/move_button_conditioner.sv
// ---------------------------------------------------------------------------
// move_button_conditioner
//
// Conditions four raw active-low pushbuttons into single-cycle, active-low
// move strobes for the cursor controller. Each button is synchronized with
// two flops and debounced with its own counter. A debounced press produces
// one strobe on the following edge. Simultaneous presses are resolved by
// priority up > down > left > right, and the losers are dropped.
//
// Optional feature (compile-time macro AUTO_REPEAT_EN): a held button
// auto-repeats. The first repeat comes REPEAT_DELAY cycles after the strobed
// press, and later repeats follow every REPEAT_PERIOD cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   btn_up_n     raw pushbutton, active-low (also down/left/right)
//   move_up      registered strobe, active-low, one cycle (also down/left/right)
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronized cycles needed to accept a change (1..65535)
//   REPEAT_DELAY     hold time before the first repeat strobe (>= 1)
//   REPEAT_PERIOD    spacing of subsequent repeat strobes (>= 1)
// ---------------------------------------------------------------------------
module move_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 50,
   parameter int REPEAT_PERIOD   = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_n,
   input  logic btn_down_n,
   input  logic btn_left_n,
   input  logic btn_right_n,
   output logic move_up,
   output logic move_down,
   output logic move_left,
   output logic move_right
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   // The counter value seen on the edge that completes the stable window.
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // Bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right.
   logic [3:0] raw_n;
   logic [3:0] press;
   logic [3:0] press_sel;
   logic [3:0] strobe_n_q;

   assign raw_n = {btn_right_n, btn_left_n, btn_down_n, btn_up_n};

`ifdef AUTO_REPEAT_EN
   logic [3:0] release_evt;
`endif

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
         logic            sync1_q;
         logic            sync2_q;
         logic            deb_q;
         logic            deb_prev_q;
         logic [DB_W-1:0] db_cnt_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sync1_q    <= 1'b1;
               sync2_q    <= 1'b1;
               deb_q      <= 1'b1;
               deb_prev_q <= 1'b1;
               db_cnt_q   <= '0;
            end else begin
               sync1_q    <= raw_n[gi];
               sync2_q    <= sync1_q;
               deb_prev_q <= deb_q;
               if (sync2_q == deb_q) begin
                  db_cnt_q <= '0;
               end else if (db_cnt_q == DB_LAST) begin
                  deb_q    <= sync2_q;
                  db_cnt_q <= '0;
               end else begin
                  db_cnt_q <= db_cnt_q + 1'b1;
               end
            end
         end

         // Events are taken one cycle after the debounced level moves, so
         // the strobe lands on the edge after the change.
         assign press[gi] = deb_prev_q & ~deb_q;
`ifdef AUTO_REPEAT_EN
         assign release_evt[gi] = ~deb_prev_q & deb_q;
`endif
      end
   endgenerate

   // Fixed priority: only the highest-priority press of a cycle survives.
   always_comb begin
      press_sel = 4'b0000;
      if (press[0])      press_sel = 4'b0001;
      else if (press[1]) press_sel = 4'b0010;
      else if (press[2]) press_sel = 4'b0100;
      else if (press[3]) press_sel = 4'b1000;
   end

`ifdef AUTO_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   state_t           state_q;
   logic [1:0]       active_q;
   logic [RPT_W-1:0] rpt_cnt_q;
   logic [1:0]       press_dir;
   logic [RPT_W-1:0] rpt_last;

   always_comb begin
      press_dir = 2'd0;
      if (press[0])      press_dir = 2'd0;
      else if (press[1]) press_dir = 2'd1;
      else if (press[2]) press_dir = 2'd2;
      else if (press[3]) press_dir = 2'd3;
   end

   assign rpt_last = (state_q == ST_HOLD) ? DELAY_LAST : PERIOD_LAST;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         active_q   <= 2'd0;
         rpt_cnt_q  <= '0;
         strobe_n_q <= 4'hF;
      end else begin
         strobe_n_q <= 4'hF;
         if (|press) begin
            // A new press always wins over a pending repeat and becomes active.
            strobe_n_q <= ~press_sel;
            active_q   <= press_dir;
            state_q    <= ST_HOLD;
            rpt_cnt_q  <= '0;
         end else begin
            case (state_q)
               ST_HOLD, ST_REPEAT: begin
                  if (release_evt[active_q]) begin
                     // Release beats a repeat that would fire this same edge.
                     state_q   <= ST_IDLE;
                     rpt_cnt_q <= '0;
                  end else if (rpt_cnt_q == rpt_last) begin
                     strobe_n_q[active_q] <= 1'b0;
                     state_q              <= ST_REPEAT;
                     rpt_cnt_q            <= '0;
                  end else begin
                     rpt_cnt_q <= rpt_cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q   <= ST_IDLE;
                  rpt_cnt_q <= '0;
               end
            endcase
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         strobe_n_q <= 4'hF;
      end else begin
         strobe_n_q <= ~press_sel;
      end
   end
`endif

   assign move_up    = strobe_n_q[0];
   assign move_down  = strobe_n_q[1];
   assign move_left  = strobe_n_q[2];
   assign move_right = strobe_n_q[3];

endmodule

// File: tb/tb_move_button_conditioner.sv
module tb_move_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_n = 4'hF;   // 0 up, 1 down, 2 left, 3 right
   logic       move_up, move_down, move_left, move_right;

   always #5 clk = ~clk;

   move_button_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_up_n    (btn_n[0]),
      .btn_down_n  (btn_n[1]),
      .btn_left_n  (btn_n[2]),
      .btn_right_n (btn_n[3]),
      .move_up     (move_up),
      .move_down   (move_down),
      .move_left   (move_left),
      .move_right  (move_right)
   );

   int n_cmp = 0;
   int n_err = 0;
   int ecount = 0;

   // Reference model: raw sample history per button, debounced level,
   // pending events, and a time-stamp based auto-repeat tracker.
   logic [31:0] hist [4];
   bit          mdeb [4];
   bit          to0  [4];
   bit          to1  [4];
   int          mstate;     // 0 idle, 1 waiting for first repeat, 2 repeating
   int          mactive;
   int          mlast;      // edge of the most recent strobe of the active direction
   logic [3:0]  exp_n = 4'hF;
   int          obs_q [4][$];

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecount);
      end
   endtask

   function automatic logic [3:0] outs();
      return {move_right, move_left, move_down, move_up};
   endfunction

   function automatic void model_reset();
      for (int b = 0; b < 4; b++) begin
         hist[b] = '1;
         mdeb[b] = 1'b1;
         to0[b]  = 1'b0;
         to1[b]  = 1'b0;
      end
      mstate  = 0;
      mactive = 0;
      mlast   = 0;
      exp_n   = 4'hF;
   endfunction

   function automatic void model_edge(input logic [3:0] raw);
      bit press [4];
      bit rel   [4];
      bit all_diff;
      int sel;
      for (int b = 0; b < 4; b++) begin
         hist[b]  = {hist[b][30:0], raw[b]};
         press[b] = to0[b];
         rel[b]   = to1[b];
         to0[b]   = 1'b0;
         to1[b]   = 1'b0;
         // The synchronizer delays a raw sample by two edges; a change is
         // accepted once the last D synchronized samples all differ.
         all_diff = 1'b1;
         for (int k = 2; k <= D + 1; k++)
            if (hist[b][k] == mdeb[b]) all_diff = 1'b0;
         if (all_diff) begin
            if (mdeb[b]) to0[b] = 1'b1;
            else         to1[b] = 1'b1;
            mdeb[b] = ~mdeb[b];
         end
      end
      exp_n = 4'hF;
      sel = -1;
      for (int b = 3; b >= 0; b--)
         if (press[b]) sel = b;
      if (sel >= 0) begin
         exp_n[sel] = 1'b0;
         mstate  = 1;
         mactive = sel;
         mlast   = ecount;
      end
`ifdef AUTO_REPEAT_EN
      else if (mstate != 0) begin
         if (rel[mactive]) begin
            mstate = 0;
         end else if (ecount - mlast == ((mstate == 1) ? RD : RP)) begin
            exp_n[mactive] = 1'b0;
            mstate = 2;
            mlast  = ecount;
         end
      end
`endif
   endfunction

   task automatic step();
      logic [3:0] got;
      @(posedge clk);
      ecount++;
      model_edge(btn_n);
      @(negedge clk);
      got = outs();
      check("strobes", 32'(got), 32'(exp_n));
      for (int b = 0; b < 4; b++)
         if (got[b] == 1'b0) obs_q[b].push_back(ecount);
      if (got != 4'hF || exp_n != 4'hF)
         $display("edge %0d: strobes_n=%b expected=%b", ecount, got, exp_n);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Called between edges; asserts reset, checks the async clear, holds it.
   task automatic apply_reset(input int cycles);
      rst = 1'b0;
      #1;
      check("rst_async", 32'(outs()), 32'hF);
      model_reset();
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      check("rst_hold", 32'(outs()), 32'hF);
      rst = 1'b1;
   endtask

   task automatic clear_obs();
      for (int b = 0; b < 4; b++) obs_q[b].delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int exp_list[$];
      int dur [4];

      #1;
      apply_reset(2);
      steps(3);

      // Single press with latency D+3
      clear_obs();
      base = ecount;
      btn_n[0] = 1'b0;
      steps(12);
      check("up_count", obs_q[0].size(), 1);
      if (obs_q[0].size() > 0) check("up_edge", obs_q[0][0] - base, 7);
      check("others_quiet", obs_q[1].size() + obs_q[2].size() + obs_q[3].size(), 0);
      btn_n[0] = 1'b1;
      steps(25);

      // Glitch of D-1 cycles is rejected, D cycles is accepted
      clear_obs();
      btn_n[2] = 1'b0;
      steps(3);
      btn_n[2] = 1'b1;
      steps(15);
      check("glitch3_left", obs_q[2].size(), 0);
      base = ecount;
      btn_n[2] = 1'b0;
      steps(4);
      btn_n[2] = 1'b1;
      steps(15);
      check("pulse4_left", obs_q[2].size(), 1);
      if (obs_q[2].size() > 0) check("pulse4_edge", obs_q[2][0] - base, 7);

      // Simultaneous down + right: only down; right only after re-press
      clear_obs();
      base = ecount;
      btn_n[1] = 1'b0;
      btn_n[3] = 1'b0;
      steps(12);
      check("simul_down", obs_q[1].size(), 1);
      if (obs_q[1].size() > 0) check("simul_down_edge", obs_q[1][0] - base, 7);
      btn_n[1] = 1'b1;
      steps(30);
      check("simul_right_dropped", obs_q[3].size(), 0);
      btn_n[3] = 1'b1;
      steps(10);
      base = ecount;
      btn_n[3] = 1'b0;
      steps(10);
      check("right_repress", obs_q[3].size(), 1);
      if (obs_q[3].size() > 0) check("right_repress_edge", obs_q[3][0] - base, 7);
      btn_n[3] = 1'b1;
      steps(15);

      // Long hold; the raw release is timed so the debounced release
      // coincides with the repeat slot at edge 42, which must be suppressed
      clear_obs();
      base = ecount;
      btn_n[3] = 1'b0;
      steps(35);
      btn_n[3] = 1'b1;
      steps(25);
`ifdef AUTO_REPEAT_EN
      exp_list = '{7, 17, 22, 27, 32, 37};
`else
      exp_list = '{7};
`endif
      check("hold_count", obs_q[3].size(), exp_list.size());
      for (int i = 0; i < exp_list.size() && i < obs_q[3].size(); i++)
         check("hold_edge", obs_q[3][i] - base, exp_list[i]);

      // Reset mid-debounce with the button still held
      clear_obs();
      btn_n[0] = 1'b0;
      steps(5);
      apply_reset(2);
      check("rst_no_strobe", obs_q[0].size(), 0);
      base = ecount;
      steps(12);
      check("rst_up_count", obs_q[0].size(), 1);
      if (obs_q[0].size() > 0) check("rst_up_edge", obs_q[0][0] - base, 7);
      btn_n[0] = 1'b1;
      steps(25);

      // Randomized traffic against the model, with occasional async resets
      for (int b = 0; b < 4; b++) dur[b] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++) begin
            if (dur[b] == 0) begin
               btn_n[b] = ~btn_n[b];
               dur[b] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6))
                                                    : int'($urandom_range(7, 45));
            end
            dur[b]--;
         end
         step();
         if (exp_n != 4'hF && $urandom_range(0, 19) == 0)
            apply_reset(int'($urandom_range(1, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
